// File: rtl/sersub_pkg.sv
// Shared definitions for the bit-serial subtractor.
// State encoding and default operand width.
package sersub_pkg;

   localparam int SERSUB_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fs_cell.sv
// One-bit full subtractor: d = a - b - bin.
// Purely combinational.
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bin;
   assign bo = (~a & (b ^ bin)) | (b & bin);

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial A - B - Bin, LSB first, with start/busy/done.
// Optional signed overflow output under SERSUB_OVF_EN.
module serial_subtractor_ctrl
   import sersub_pkg::*;
#(
   parameter  int WIDTH = SERSUB_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             bin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             bout_o
`ifdef SERSUB_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             brw;
   logic [CNT_W-1:0] cnt;
   logic             d;
   logic             bo;

   fs_cell u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .bin (brw),
      .d   (d),
      .bo  (bo)
   );

   // FSM, operand/result shifting and registered outputs.
   // Result bits fill the minuend register from the top as its
   // consumed bits leave at the bottom, so after WIDTH steps it
   // holds the full difference.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
         diff_o <= '0;
         bout_o <= 1'b0;
`ifdef SERSUB_OVF_EN
         ovf_o  <= 1'b0;
`endif
      end else begin
         unique case (state)
            ST_IDLE, ST_DONE: begin
               done_o <= 1'b0;
               if (start_i) begin
                  a_sh   <= a_i;
                  b_sh   <= b_i;
                  brw    <= bin_i;
                  cnt    <= '0;
                  busy_o <= 1'b1;
                  state  <= ST_RUN;
               end else begin
                  state  <= ST_IDLE;
               end
            end
            ST_RUN: begin
               a_sh <= {d, a_sh[WIDTH-1:1]};
               b_sh <= b_sh >> 1;
               brw  <= bo;
               if (cnt == CNT_LAST) begin
                  cnt    <= '0;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
                  diff_o <= {d, a_sh[WIDTH-1:1]};
                  bout_o <= bo;
`ifdef SERSUB_OVF_EN
                  ovf_o  <= (a_sh[0] ^ b_sh[0])
                          & (a_sh[0] ^ d);
`endif
                  state  <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               busy_o <= 1'b0;
               done_o <= 1'b0;
               state  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl (WIDTH=8).
// Expected results are queued at start and popped at done.
module tb_serial_subtractor_ctrl;

   localparam int W = 8;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         bin   = 1'b0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERSUB_OVF_EN
   logic         ovf;
`endif

   typedef struct packed {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   serial_subtractor_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .bin_i   (bin),
      .busy_o  (busy),
      .done_o  (done),
      .diff_o  (diff),
      .bout_o  (bout)
`ifdef SERSUB_OVF_EN
      ,
      .ovf_o   (ovf)
`endif
   );

   // free-running clock, period 10
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] aa,
                                  input logic [W-1:0] bb,
                                  input logic         bi);
      exp_t       e;
      logic [W:0] r;
      r      = {1'b0, aa} - {1'b0, bb} - {{W{1'b0}}, bi};
      e.diff = r[W-1:0];
      e.bout = r[W];
      e.ovf  = (aa[W-1] ^ bb[W-1]) & (aa[W-1] ^ r[W-1]);
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (q.size() == 0) begin
         chk({tag, "_qempty"}, 32'd0, 32'd1);
      end else begin
         e = q.pop_front();
         chk({tag, "_diff"}, 32'(diff), 32'(e.diff));
         chk({tag, "_bout"}, 32'(bout), 32'(e.bout));
`ifdef SERSUB_OVF_EN
         chk({tag, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
      end
   endtask

   // single operation; optional stray start at RUN step ign_at
   task automatic op(input logic [W-1:0] aa,
                     input logic [W-1:0] bb,
                     input logic         bi,
                     input int           ign_at,
                     input string        tag);
      logic [W-1:0] held;
      int           n;
      held  = diff;
      a     = aa;
      b     = bb;
      bin   = bi;
      start = 1'b1;
      q.push_back(model(aa, bb, bi));
      step();
      start = 1'b0;
      a     = 8'hC3;
      b     = 8'h3C;
      bin   = ~bi;
      chk({tag, "_busy1"}, 32'(busy), 32'd1);
      chk({tag, "_hold"}, 32'(diff), 32'(held));
      n = 0;
      do begin
         if (n == ign_at) begin
            start = 1'b1;
            a     = 8'hFF;
            b     = 8'h00;
         end else begin
            start = 1'b0;
         end
         step();
         n++;
      end while (!done && n < 40);
      start = 1'b0;
      chk({tag, "_lat"}, 32'(n), 32'(W));
      chk({tag, "_busy0"}, 32'(busy), 32'd0);
      pop_check(tag);
      step();
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [W-1:0] la [4];
      logic [W-1:0] lb [4];
      logic         lc [4];
      int           n;

      la = '{8'h10, 8'h00, 8'hFF, 8'h7E};
      lb = '{8'h01, 8'h01, 8'hFE, 8'h7F};
      lc = '{1'b0, 1'b1, 1'b1, 1'b0};

      #2;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_diff", 32'(diff), 32'd0);
      chk("rst_bout", 32'(bout), 32'd0);
      #10 rst_n = 1'b1;
      step();

      op(8'h35, 8'h12, 1'b0, -1, "sub1");
      op(8'h12, 8'h35, 1'b0, -1, "sub2");
      op(8'h00, 8'h00, 1'b1, -1, "sub3");
      op(8'h5A, 8'h21, 1'b1, 2, "ign");
`ifdef SERSUB_OVF_EN
      op(8'h80, 8'h01, 1'b0, -1, "ovf1");
      op(8'h05, 8'h03, 1'b0, -1, "ovf0");
`endif

      // back-to-back with start held high
      a     = la[0];
      b     = lb[0];
      bin   = lc[0];
      start = 1'b1;
      q.push_back(model(la[0], lb[0], lc[0]));
      step();
      chk("b2b_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         n = 0;
         do begin
            step();
            n++;
         end while (!done && n < 40);
         chk("b2b_gap", 32'(n), (i == 0) ? 32'(W) : 32'(W + 1));
         chk("b2b_busy0", 32'(busy), 32'd0);
         pop_check("b2b");
         if (i < 3) begin
            a   = la[i+1];
            b   = lb[i+1];
            bin = lc[i+1];
            q.push_back(model(la[i+1], lb[i+1], lc[i+1]));
         end else begin
            start = 1'b0;
         end
      end
      step();
      chk("b2b_end", 32'(done), 32'd0);

      // reset during RUN cycle 4
      a     = 8'h77;
      b     = 8'h11;
      bin   = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("pre_rst_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_diff", 32'(diff), 32'd0);
      chk("arst_bout", 32'(bout), 32'd0);
      step();
      #3 rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         chk("arst_nodone", 32'(done), 32'd0);
      end
      op(8'h40, 8'h41, 1'b1, -1, "post");

      chk("q_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor_ctrl.md
Name: serial_subtractor_ctrl

Overview:
Bit-serial N-bit subtractor. The block sequences a single 1-bit full-subtractor cell over WIDTH clock cycles, LSB first, to compute A - B - Bin. It provides a start/busy/done handshake for a requesting controller. It trades area for latency wherever a full ripple subtractor is too large.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start_i  input  1  request pulse; sampled only when accepted (see Behaviour).
a_i  input  WIDTH  minuend; captured on accepted start.
b_i  input  WIDTH  subtrahend; captured on accepted start.
bin_i  input  1  borrow-in; captured on accepted start.
busy_o  output  1  high while the operation is in progress.
done_o  output  1  single-cycle pulse when the result is valid.
diff_o  output  WIDTH  difference; registered, held until next accepted start.
bout_o  output  1  final borrow-out; registered, held until next accepted start.
ovf_o  output  1  signed overflow; present only with SERSUB_OVF_EN.

Behaviour:
- Reset (async assert, sync deassert handled upstream): state=IDLE; busy_o=0, done_o=0, diff_o=0, bout_o=0, ovf_o=0; shift regs, borrow reg and counter=0.
- States: IDLE, RUN, DONE. Encoding 2 bits, defined in the package.
- IDLE: start_i=1 -> load a_sh<=a_i, b_sh<=b_i, brw<=bin_i, cnt<=0; go RUN.
- RUN: busy_o=1.
  - Cell inputs per cycle: a_sh[0], b_sh[0], brw.
  - Cell equations: d = a^b^brw; bo = (~a&(b^brw)) | (b&brw).
  - Each clock: a_sh, b_sh shift right by 1; d shifts into res[WIDTH-1] (res shifts right); brw<=bo; cnt++.
  - cnt==WIDTH-1 on an edge -> go DONE. On that same edge: diff_o<=final res, bout_o<=bo.
- DONE: done_o=1 for exactly one cycle; busy_o=0.
  - Next state IDLE, or RUN if start_i=1 in this cycle (back-to-back accepted; new operands loaded).
- Latency: if start_i is sampled at edge k, done_o is high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from start.
  - Throughput: one result per WIDTH+1 cycles.
- start_i during RUN: ignored, no queuing. Operands already captured are unaffected by later a_i/b_i changes.
- diff_o/bout_o update only at RUN->DONE. They hold through IDLE and through the next RUN until its completion.
- Arithmetic: diff_o = (a_i - b_i - bin_i) mod 2^WIDTH. bout_o=1 iff a_i < b_i + bin_i (unsigned).
- rst_n low mid-RUN: immediate abort to reset values. No done_o pulse; partial result discarded.
- Counter wrap: cnt never exceeds WIDTH-1 and is cleared on every load.

Optional Feature:
Macro SERSUB_OVF_EN.
- Defined: port ovf_o exists. On the final RUN edge, ovf_o <= (a_msb ^ b_msb) & (a_msb ^ d_msb), using the operand MSBs at that step. ovf_o is held like diff_o and reset to 0.
- Undefined: the ovf_o port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package sersub_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default WIDTH constant.
- One sub-module: fs_cell, a purely combinational 1-bit full subtractor (a, b, bin -> d, bo), instantiated once.
- The FSM, shift registers and counter stay in serial_subtractor_ctrl.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, bin=0, start 1 cycle -> busy 8 cycles; done pulse at cycle 9; diff=0x23, bout=0.
- a=0x12, b=0x35, bin=0 -> diff=0xDD, bout=1. a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Back-to-back: start held high continuously with new operands each done -> every result correct; done pulses exactly 9 cycles apart; no idle cycle.
- start pulsed at RUN cycle 3 with a=0xFF, b=0x00 -> ignored; first result unaffected; busy does not extend.
- rst_n low during RUN cycle 4 -> all outputs 0 immediately; no done pulse; next start computes correctly.
- SERSUB_OVF_EN defined: a=0x80, b=0x01 -> diff=0x7F, ovf=1. a=0x05, b=0x03 -> diff=0x02, ovf=0.
